alu_issue: RTL and testbench
============================

ALU_ISSUE -- requirements
Module: alu_issue

Interface
REQ-001: Parameter DEPTH, default 4, FIFO entry count; SHALL be a power of two, minimum 2.
REQ-002: Parameter WIDTH, default 32, operand/result width.
REQ-003: clk_in  input  1  single clock; all state SHALL update on its rising edge.
REQ-004: rst_n_in  input  1  reset; SHALL be synchronous and active-low.
REQ-005: in_valid_in  input  1  upstream operation valid.
REQ-006: in_ready_out  output  1  block can accept an operation.
REQ-007: a_in, b_in  input  WIDTH each  operands, bit 0 = MSB ([0:WIDTH-1] ordering).
REQ-008: op_in  input  3  ALU opcode ([0:2] ordering).
REQ-009: alu_a_out, alu_b_out  output  WIDTH each  operands driven to the combinational ALU a_in/b_in.
REQ-010: alu_op_out  output  3  opcode driven to ALU op_in.
REQ-011: alu_y_in  input  WIDTH  ALU y_out, combinational from alu_*_out.
REQ-012: alu_z_in  input  1  ALU z_out.
REQ-013: res_valid_out  output  1  result register holds a result.
REQ-014: res_ready_in  input  1  downstream accepts result.
REQ-015: res_y_out  output  WIDTH; res_z_out  output  1; res_op_out  output  3  registered result, zero flag, originating opcode.
REQ-016: count_out  output  log2(DEPTH)+1  current FIFO occupancy.

Function
REQ-017: Push SHALL occur on an edge where in_valid_in=1 and in_ready_out=1; entry {a_in,b_in,op_in} written at write pointer.
REQ-018: in_ready_out SHALL equal (count_out < DEPTH), from registered state only; no same-cycle full pass-through.
REQ-019: alu_a_out/alu_b_out/alu_op_out SHALL present the head entry combinationally when count_out>0, all zeros when count_out=0.
REQ-020: Pop SHALL occur on an edge where count_out>0 and (res_valid_out=0 or res_ready_in=1); on pop, res_y_out<=alu_y_in, res_z_out<=alu_z_in, res_op_out<=head op, res_valid_out<=1.
REQ-021: On an edge with res_valid_out=1, res_ready_in=1 and no pop, res_valid_out SHALL go 0; res_y/z/op SHALL hold.
REQ-022: Latency: operation pushed at edge N into an empty FIFO with free result register SHALL show res_valid_out=1 after edge N+1.
REQ-023: Throughput: one result per cycle sustained when in_valid_in and res_ready_in held high.
REQ-024: Results SHALL leave in push order; no drop, no duplication.
REQ-025: Simultaneous push and pop SHALL leave count_out unchanged; push-only +1, pop-only -1.
REQ-026: Read/write pointers SHALL be log2(DEPTH) bits and wrap DEPTH-1 -> 0.
REQ-027: Push while full SHALL be impossible (in_ready_out=0); pop while empty SHALL not occur and SHALL not change state.
REQ-028: Result register SHALL hold all outputs stable while res_valid_out=1 and res_ready_in=0.

Reset
REQ-029: When rst_n_in=0 at an edge: pointers 0, count_out 0, res_valid_out 0, res_y_out 0, res_z_out 0, res_op_out 0; FIFO storage need not be cleared.
REQ-030: Reset mid-operation SHALL discard all queued and held results; in_ready_out=1 the cycle after reset releases.
REQ-031: Reset SHALL take priority over push and pop in the same cycle.

Configuration
REQ-032: Macro ALU_ISSUE_ZCNT_EN defined: extra output zcnt_out (16 bits) SHALL count pops with alu_z_in=1, saturate at 16'hFFFF, reset to 0.
REQ-033: Macro ALU_ISSUE_ZCNT_EN undefined: zcnt_out port and counter SHALL not exist; all other behaviour identical.

Verification
REQ-034: Reset, then push a=1, b=1, op=3'b000, res_ready_in=1 -> one cycle later res_valid_out=1, res_y_out=2, res_z_out=0, res_op_out=0.
REQ-035: res_ready_in=0, push 6 ops back-to-back -> 5 accepted (1 in result reg, 4 queued), count_out=4, in_ready_out=0 on 6th; then res_ready_in=1 -> all 5 drain in order.
REQ-036: Push a=5, b=5, op=3'b001 (subtract) -> res_y_out=0, res_z_out=1; with ALU_ISSUE_ZCNT_EN, zcnt_out increments 0->1.
REQ-037: Continuous push/pop for 10 ops with DEPTH=4 -> pointers wrap, count_out stays <=1, results match push order.
REQ-038: Assert rst_n_in=0 with count_out=3 and res_valid_out=1 -> next cycle count_out=0, res_valid_out=0, res_y_out=0, in_ready_out=1.

Source files
------------

// File: rtl/alu_issue.sv
// alu_issue: operation FIFO feeding an external combinational ALU, with a registered result stage.
// Optional macro ALU_ISSUE_ZCNT_EN adds zcnt_out, a saturating count of zero-flag results.
`default_nettype none

module alu_issue #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 32
) (
  input  logic                       clk_in,
  input  logic                       rst_n_in,
  input  logic                       in_valid_in,
  output logic                       in_ready_out,
  input  logic [0:WIDTH-1]           a_in,
  input  logic [0:WIDTH-1]           b_in,
  input  logic [0:2]                 op_in,
  output logic [WIDTH-1:0]           alu_a_out,
  output logic [WIDTH-1:0]           alu_b_out,
  output logic [2:0]                 alu_op_out,
  input  logic [WIDTH-1:0]           alu_y_in,
  input  logic                       alu_z_in,
  output logic                       res_valid_out,
  input  logic                       res_ready_in,
  output logic [WIDTH-1:0]           res_y_out,
  output logic                       res_z_out,
  output logic [2:0]                 res_op_out,
`ifdef ALU_ISSUE_ZCNT_EN
  output logic [15:0]                zcnt_out,
`endif
  output logic [$clog2(DEPTH):0]     count_out
);

  localparam int c_AW = $clog2(DEPTH);
  localparam logic [c_AW:0] c_DEPTH = (c_AW+1)'(DEPTH);

  logic [WIDTH-1:0] r_mem_a  [DEPTH];
  logic [WIDTH-1:0] r_mem_b  [DEPTH];
  logic [2:0]       r_mem_op [DEPTH];

  logic [c_AW-1:0]  r_wptr;
  logic [c_AW-1:0]  r_rptr;
  logic [c_AW:0]    r_count;
  logic             r_res_valid;
  logic [WIDTH-1:0] r_res_y;
  logic             r_res_z;
  logic [2:0]       r_res_op;

  logic w_empty;
  logic w_push;
  logic w_pop;

  assign w_empty      = (r_count == '0);
  assign in_ready_out = (r_count < c_DEPTH);
  assign w_push       = in_valid_in && in_ready_out;
  // The result register frees up on the same edge it is consumed, giving one result per cycle.
  assign w_pop        = !w_empty && (!r_res_valid || res_ready_in);

  assign alu_a_out  = w_empty ? '0 : r_mem_a[r_rptr];
  assign alu_b_out  = w_empty ? '0 : r_mem_b[r_rptr];
  assign alu_op_out = w_empty ? '0 : r_mem_op[r_rptr];

  assign count_out     = r_count;
  assign res_valid_out = r_res_valid;
  assign res_y_out     = r_res_y;
  assign res_z_out     = r_res_z;
  assign res_op_out    = r_res_op;

  always_ff @(posedge clk_in) begin
    if (w_push && rst_n_in) begin
      r_mem_a[r_wptr]  <= a_in;
      r_mem_b[r_wptr]  <= b_in;
      r_mem_op[r_wptr] <= op_in;
    end
  end

  always_ff @(posedge clk_in) begin
    if (!rst_n_in) begin
      r_wptr      <= '0;
      r_rptr      <= '0;
      r_count     <= '0;
      r_res_valid <= 1'b0;
      r_res_y     <= '0;
      r_res_z     <= 1'b0;
      r_res_op    <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + 1'b1;
      if (w_pop)  r_rptr <= r_rptr + 1'b1;
      if (w_push && !w_pop)      r_count <= r_count + 1'b1;
      else if (w_pop && !w_push) r_count <= r_count - 1'b1;
      if (w_pop) begin
        r_res_valid <= 1'b1;
        r_res_y     <= alu_y_in;
        r_res_z     <= alu_z_in;
        r_res_op    <= alu_op_out;
      end else if (res_ready_in) begin
        r_res_valid <= 1'b0;
      end
    end
  end

`ifdef ALU_ISSUE_ZCNT_EN
  logic [15:0] r_zcnt;
  assign zcnt_out = r_zcnt;

  always_ff @(posedge clk_in) begin
    if (!rst_n_in)                                r_zcnt <= '0;
    else if (w_pop && alu_z_in && r_zcnt != 16'hFFFF) r_zcnt <= r_zcnt + 16'd1;
  end
`endif

endmodule

`default_nettype wire

// File: tb/tb_alu_issue.sv
// tb_alu_issue: scoreboard bench for alu_issue with a bench-side combinational ALU.
`default_nettype none

module tb_alu_issue;

  localparam int DEPTH = 4;
  localparam int WIDTH = 32;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [0:WIDTH-1] a = '0;
  logic [0:WIDTH-1] b = '0;
  logic [0:2]       op = '0;
  logic [WIDTH-1:0] alu_a, alu_b, alu_y;
  logic [2:0]       alu_op;
  logic             alu_z;
  logic             res_valid;
  logic             res_ready = 1'b0;
  logic [WIDTH-1:0] res_y;
  logic             res_z;
  logic [2:0]       res_op;
  logic [2:0]       count;
`ifdef ALU_ISSUE_ZCNT_EN
  logic [15:0]      zcnt;
`endif

  int n_checks = 0;
  int n_errors = 0;
  logic [63:0] sb_q [$];

  always #5 clk = ~clk;

  alu_issue #(.DEPTH(DEPTH), .WIDTH(WIDTH)) dut (
    .clk_in(clk), .rst_n_in(rst_n), .in_valid_in(in_valid), .in_ready_out(in_ready),
    .a_in(a), .b_in(b), .op_in(op),
    .alu_a_out(alu_a), .alu_b_out(alu_b), .alu_op_out(alu_op),
    .alu_y_in(alu_y), .alu_z_in(alu_z),
    .res_valid_out(res_valid), .res_ready_in(res_ready),
    .res_y_out(res_y), .res_z_out(res_z), .res_op_out(res_op),
`ifdef ALU_ISSUE_ZCNT_EN
    .zcnt_out(zcnt),
`endif
    .count_out(count)
  );

  function automatic logic [WIDTH-1:0] alu_f(logic [WIDTH-1:0] x, logic [WIDTH-1:0] y, logic [2:0] o);
    case (o)
      3'd0:    return x + y;
      3'd1:    return x - y;
      3'd2:    return x & y;
      3'd3:    return x | y;
      3'd4:    return x ^ y;
      default: return x;
    endcase
  endfunction

  always_comb begin
    alu_y = alu_f(alu_a, alu_b, alu_op);
    alu_z = (alu_y == '0);
  end

  function automatic logic [63:0] expect_res(logic [WIDTH-1:0] x, logic [WIDTH-1:0] y, logic [2:0] o);
    logic [WIDTH-1:0] r;
    r = alu_f(x, y, o);
    return {28'd0, o, (r == '0), r};
  endfunction

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y, input logic [2:0] o);
    in_valid = v;
    a = x;
    b = y;
    op = o;
  endtask

  // Called at a falling edge with inputs settled; books the upcoming edge's handshakes.
  task automatic tick();
    logic [63:0] e;
    if (!rst_n) begin
      sb_q.delete();
    end else begin
      if (res_valid && res_ready) begin
        if (sb_q.size() == 0) chk("sb_underflow", 64'd1, 64'd0);
        else begin
          e = sb_q.pop_front();
          chk("result", {28'd0, res_op, res_z, res_y}, e);
        end
      end
      if (in_valid && in_ready) sb_q.push_back(expect_res(a, b, op));
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic drain();
    drive(1'b0, '0, '0, '0);
    res_ready = 1'b1;
    for (int i = 0; i < 40; i++) begin
      if (sb_q.size() == 0 && !res_valid) break;
      tick();
    end
    chk("drained", 64'(sb_q.size()), 64'd0);
  endtask

  initial begin
    int acc;
    logic [WIDTH-1:0] held_y;
    @(negedge clk);
    tick();
    tick();
    chk("rst_count", 64'(count), 64'd0);
    chk("rst_valid", 64'(res_valid), 64'd0);
    chk("rst_y", 64'(res_y), 64'd0);
    chk("rst_z_op", 64'({res_z, res_op}), 64'd0);
    chk("rst_ready", 64'(in_ready), 64'd1);
    chk("empty_alu_a", 64'(alu_a), 64'd0);
    rst_n = 1'b1;
    tick();
    chk("idle_count", 64'(count), 64'd0);
    chk("idle_valid", 64'(res_valid), 64'd0);

    // Basic add and latency
    res_ready = 1'b1;
    drive(1'b1, 32'd1, 32'd1, 3'b000);
    tick();
    drive(1'b0, '0, '0, '0);
    chk("lat_cnt1", 64'(count), 64'd1);
    chk("lat_valid0", 64'(res_valid), 64'd0);
    chk("head_a", 64'(alu_a), 64'd1);
    tick();
    chk("lat_valid1", 64'(res_valid), 64'd1);
    chk("add_y", 64'(res_y), 64'd2);
    chk("add_z_op", 64'({res_z, res_op}), 64'd0);
    tick();
    chk("consumed", 64'(res_valid), 64'd0);

    // Subtract to zero
    drive(1'b1, 32'd5, 32'd5, 3'b001);
    tick();
    drive(1'b0, '0, '0, '0);
    tick();
    chk("sub_y", 64'(res_y), 64'd0);
    chk("sub_z", 64'(res_z), 64'd1);
`ifdef ALU_ISSUE_ZCNT_EN
    chk("zcnt", 64'(zcnt), 64'd1);
`endif
    tick();

    // Back-pressure fill
    res_ready = 1'b0;
    acc = 0;
    for (int i = 0; i < 6; i++) begin
      drive(1'b1, 32'(i + 10), 32'(i), 3'b000);
      if (i == 5) chk("full_ready", 64'(in_ready), 64'd0);
      if (in_ready) acc++;
      tick();
    end
    drive(1'b0, '0, '0, '0);
    chk("accepted", 64'(acc), 64'd5);
    chk("full_count", 64'(count), 64'd4);
    held_y = res_y;
    tick();
    tick();
    chk("stall_hold", 64'(res_y), 64'(held_y));
    chk("stall_y", 64'(res_y), 64'd10);
    chk("stall_valid", 64'(res_valid), 64'd1);
    drain();

    // Streaming with wrap
    res_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      drive(1'b1, 32'(i * 7 + 3), 32'(i), 3'(i % 5));
      tick();
      chk("stream_cnt", 64'(count <= 3'd1), 64'd1);
    end
    drain();

    // Random traffic
    for (int i = 0; i < 300; i++) begin
      drive(1'($urandom_range(0, 1)), $urandom, $urandom_range(0, 3) == 0 ? 32'd0 : $urandom,
            3'($urandom_range(0, 7)));
      res_ready = 1'($urandom_range(0, 2) != 0);
      tick();
    end
    drain();

    // Reset mid-operation, with push attempted during reset
    res_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 32'(i + 100), 32'd1, 3'b000);
      tick();
    end
    chk("pre_rst_cnt", 64'(count), 64'd3);
    chk("pre_rst_valid", 64'(res_valid), 64'd1);
    rst_n = 1'b0;
    tick();
    chk("post_rst_cnt", 64'(count), 64'd0);
    chk("post_rst_valid", 64'(res_valid), 64'd0);
    chk("post_rst_y", 64'(res_y), 64'd0);
    chk("post_rst_ready", 64'(in_ready), 64'd1);
    drive(1'b0, '0, '0, '0);
    rst_n = 1'b1;
    tick();
    chk("release_ready", 64'(in_ready), 64'd1);
    chk("release_cnt", 64'(count), 64'd0);
    drain();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule

`default_nettype wire
